spin_readout: RTL and testbench

//   Consumes the asynchronous phase outputs (dout) of the coupled-RO array and

---
 rtl/spin_readout.sv | 201 ++++++++++++++++++++
 tb/tb_spin_readout.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_readout.sv
// spin_readout: turns the asynchronous phase outputs of the coupled-RO array
// into one binary spin per oscillator. Every phase is synchronised into clk and
// XORed with the synchronised reference phase. The mismatches are counted over
// a programmable window, and a strict-majority vote per oscillator sets its spin.
//
// Ports:
//   clk         system / AXI clock
//   axi_rstn    async active-low reset
//   ising_rstn  oscillator enable (async, synchronised here); low aborts a run
//   phase_in    async oscillator phases, one per spin
//   phase_ref   async reference oscillator phase
//   start       measurement request, accepted only while idle
//   win_len     window length in clk cycles, sampled together with start
//   busy        a measurement is in progress
//   done        1-cycle pulse: spins updated
//   abort       1-cycle pulse: measurement cancelled by ising_rstn
//   err         1-cycle pulse: start rejected because win_len was 0
//   spins       last completed result, 1 = anti-phase to the reference
module spin_readout #(
  parameter int unsigned NUM_SPINS   = 32,
  parameter int unsigned WIN_BITS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 axi_rstn,
  input  logic                 ising_rstn,
  input  logic [NUM_SPINS-1:0] phase_in,
  input  logic                 phase_ref,
  input  logic                 start,
  input  logic [WIN_BITS-1:0]  win_len,
  output logic                 busy,
  output logic                 done,
  output logic                 abort,
  output logic                 err,
  output logic [NUM_SPINS-1:0] spins
);

  // Synchronised vector layout: {ising_rstn, phase_ref, phase_in}
  localparam int unsigned SYNC_W = NUM_SPINS + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [SYNC_STAGES-1:0][SYNC_W-1:0]   r_sync;
  logic [1:0]                           r_state;
  logic [WIN_BITS-1:0]                  r_len;
  logic [WIN_BITS-1:0]                  r_cyc;
  logic [NUM_SPINS-1:0][WIN_BITS-1:0]   r_cnt;
  logic [NUM_SPINS-1:0]                 r_spins;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_abort;
  logic                                 r_err;

  logic                                 w_run;
  logic                                 w_ref;
  logic [NUM_SPINS-1:0]                 w_mis;
  logic [NUM_SPINS-1:0]                 w_vote;
  logic [WIN_BITS-1:0]                  w_cyc_inc;
  logic [1:0]                           w_state_nxt;
  logic                                 w_busy_nxt;
  logic                                 w_done_nxt;
  logic                                 w_abort_nxt;
  logic                                 w_err_nxt;
  logic                                 w_clr;
  logic                                 w_acc;
  logic                                 w_load;

  // Multi-stage synchroniser for every asynchronous input
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {ising_rstn, phase_ref, phase_in}};
    end
  end

  assign w_run     = r_sync[SYNC_STAGES-1][SYNC_W-1];
  assign w_ref     = r_sync[SYNC_STAGES-1][NUM_SPINS];
  assign w_mis     = r_sync[SYNC_STAGES-1][NUM_SPINS-1:0] ^ {NUM_SPINS{w_ref}};
  assign w_cyc_inc = r_cyc + WIN_BITS'(1);

  // Strict majority: 2*cnt > len, evaluated one bit wider so nothing wraps
  always_comb begin
    w_vote = '0;
    for (int unsigned i = 0; i < NUM_SPINS; i++) begin
      w_vote[i] = ({r_cnt[i], 1'b0} > {1'b0, r_len});
    end
  end

  // State register
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; abort wins over window completion
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          if (win_len != '0) begin
            w_state_nxt = S_SAMPLE;
            w_busy_nxt  = 1'b1;
            w_clr       = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_SAMPLE: begin
        if (!w_run) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_abort_nxt = 1'b1;
        end else begin
          w_acc = 1'b1;
          if (w_cyc_inc == r_len) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        if (!w_run) begin
          w_abort_nxt = 1'b1;
        end else begin
          w_load     = 1'b1;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Window length, cycle counter and per-spin mismatch counters
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_len <= '0;
      r_cyc <= '0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_len <= win_len;
      r_cyc <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cyc <= w_cyc_inc;
      for (int unsigned i = 0; i < NUM_SPINS; i++) begin
        r_cnt[i] <= r_cnt[i] + WIN_BITS'(w_mis[i]);
      end
    end
  end

  // Result register, only touched on a completed window
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_spins <= '0;
    end else if (w_load) begin
      r_spins <= w_vote;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign abort = r_abort;
  assign err   = r_err;
  assign spins = r_spins;

endmodule

// File: tb/tb_spin_readout.sv
// Scoreboard bench for spin_readout. Stimulus plans the per-cycle phase
// sequence of each window, computes the expected spins by counting mismatches
// and voting, and queues the expected event; a negedge monitor checks events.
module tb_spin_readout;

  localparam int unsigned N  = 32;
  localparam int unsigned WB = 16;
  localparam int unsigned S  = 2;
  localparam int K_DONE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int           kind;
    int           at;
    int           len;
    logic [N-1:0] sp;
  } exp_t;

  logic          clk        = 1'b0;
  logic          axi_rstn   = 1'b1;
  logic          ising_rstn = 1'b1;
  logic [N-1:0]  phase_in   = '0;
  logic          phase_ref  = 1'b0;
  logic          start      = 1'b0;
  logic [WB-1:0] win_len    = '0;
  logic          busy;
  logic          done;
  logic          abort;
  logic          err;
  logic [N-1:0]  spins;

  always #5 clk = ~clk;

  spin_readout #(.NUM_SPINS(N), .WIN_BITS(WB), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .axi_rstn   (axi_rstn),
    .ising_rstn (ising_rstn),
    .phase_in   (phase_in),
    .phase_ref  (phase_ref),
    .start      (start),
    .win_len    (win_len),
    .busy       (busy),
    .done       (done),
    .abort      (abort),
    .err        (err),
    .spins      (spins)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  exp_t         sbq[$];
  logic [N-1:0] seq_in[$];
  logic         seq_ref[$];
  logic [N-1:0] model_spins = '0;
  int           busy_run    = 0;
  logic [N-1:0] mon_spins   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  // Reference: per spin, count mismatching cycles in the window, strict majority
  function automatic logic [N-1:0] vote();
    logic [N-1:0] r;
    int           len;
    int           c;
    r   = '0;
    len = seq_in.size();
    for (int i = 0; i < int'(N); i++) begin
      c = 0;
      for (int j = 0; j < len; j++) begin
        if (seq_in[j][i] != seq_ref[j]) c++;
      end
      r[i] = (2 * c > len);
    end
    return r;
  endfunction

  // Monitor: checks reset values, events against the scoreboard, and spins hold
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!axi_rstn) begin
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_abort", abort, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk("rst_spins", spins, '0);
      mon_spins = '0;
      busy_run  = 0;
    end else begin
      if (done || abort || err) begin
        k = done ? K_DONE : (abort ? K_ABORT : K_ERR);
        chk("evt_exclusive", int'(done) + int'(abort) + int'(err), 1);
        chk1("evt_busy_low", busy, 1'b0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event kind %0d at cycle %0d", k, cyc);
        end else begin
          e = sbq.pop_front();
          chk("evt_kind", k, e.kind);
          chk("evt_cycle", cyc, e.at);
          chk("evt_spins", spins, e.sp);
          if (e.kind == K_DONE) chk("busy_len", busy_run, e.len + 1);
          mon_spins = e.sp;
        end
      end else begin
        chk("spins_hold", spins, mon_spins);
      end
      busy_run = busy ? busy_run + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_static(input logic [N-1:0] v, input logic r, input int len);
    seq_in.delete();
    seq_ref.delete();
    for (int j = 0; j < len; j++) begin
      seq_in.push_back(v);
      seq_ref.push_back(r);
    end
  endtask

  task automatic fill_random(input int len);
    seq_in.delete();
    seq_ref.delete();
    for (int j = 0; j < len; j++) begin
      seq_in.push_back($urandom());
      seq_ref.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Drives the planned sequence so entry c is what the counters see in window
  // cycle c; start is issued S-1 cycles in. Optional extra start / enable drop.
  task automatic run_seq(input int extra_at, input int drop_at);
    int           len;
    int           n;
    int           ci;
    logic [N-1:0] prev;
    len  = seq_in.size();
    n    = (len > int'(S)) ? len : int'(S);
    prev = model_spins;
    for (int c = 0; c < n; c++) begin
      ci        = (c < len) ? c : len - 1;
      phase_in  = seq_in[ci];
      phase_ref = seq_ref[ci];
      start     = (c == int'(S) - 1) || (c == extra_at);
      win_len   = (c == extra_at) ? WB'(3) : WB'(len);
      if (c == int'(S) - 1) begin
        prev        = model_spins;
        model_spins = vote();
        sbq.push_back('{kind: K_DONE, at: cyc + len + 2, len: len, sp: model_spins});
      end
      if (c == drop_at) begin
        ising_rstn = 1'b0;
        void'(sbq.pop_back());
        model_spins = prev;
        sbq.push_back('{kind: K_ABORT, at: cyc + 1 + int'(S), len: 0, sp: prev});
      end
      tick();
      if (c == int'(S) - 1) chk1("busy_on_accept", busy, 1'b1);
    end
    start = 1'b0;
  endtask

  // Start with the phases already static on the inputs
  task automatic start_static(input int len);
    fill_static(phase_in, phase_ref, len);
    model_spins = vote();
    sbq.push_back('{kind: K_DONE, at: cyc + len + 2, len: len, sp: model_spins});
    start   = 1'b1;
    win_len = WB'(len);
    tick();
    start = 1'b0;
    chk1("busy_on_accept", busy, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d at cycle %0d", sbq.size(), cyc);
      sbq.delete();
    end
    tick();
  endtask

  initial begin
    logic [3:0] pat;
    int         len;

    // Reset
    #1 axi_rstn = 1'b0;
    repeat (3) tick();
    axi_rstn = 1'b1;
    repeat (S + 2) tick();
    chk1("idle_busy", busy, 1'b0);
    chk("idle_spins", spins, '0);

    // Static halves, 8-cycle window
    fill_static(32'h0000_FFFF, 1'b0, 8);
    run_seq(-1, -1);
    wait_drain(40);
    chk("static_half_spins", spins, 32'h0000_FFFF);

    // Spin 0: 2 of 4 mismatched is a tie -> 0, then 3 of 4 -> 1
    pat = 4'b0101;
    seq_in.delete();
    seq_ref.delete();
    for (int j = 0; j < 4; j++) begin
      seq_in.push_back({31'h7FFF_8000, pat[j]});
      seq_ref.push_back(1'b0);
    end
    run_seq(-1, -1);
    wait_drain(20);
    chk1("tie_spin0", spins[0], 1'b0);
    pat = 4'b1011;
    for (int j = 0; j < 4; j++) seq_in[j] = {31'h7FFF_8000, pat[j]};
    run_seq(-1, -1);
    wait_drain(20);
    chk1("majority_spin0", spins[0], 1'b1);

    // Shortest window
    fill_static($urandom(), 1'b1, 1);
    run_seq(-1, -1);
    wait_drain(20);

    // Zero-length start is rejected
    sbq.push_back('{kind: K_ERR, at: cyc + 1, len: 0, sp: model_spins});
    start   = 1'b1;
    win_len = '0;
    tick();
    start = 1'b0;
    chk1("err_busy", busy, 1'b0);
    wait_drain(10);

    // Start while busy is ignored
    fill_static($urandom(), 1'b0, 10);
    run_seq(5, -1);
    wait_drain(30);

    // Enable dropped mid-window
    fill_static($urandom(), 1'b1, 100);
    run_seq(-1, 50);
    chk1("abort_busy", busy, 1'b0);
    ising_rstn = 1'b1;
    repeat (S + 2) tick();
    wait_drain(10);

    // Back-to-back: second start in the done cycle
    phase_in  = $urandom();
    phase_ref = 1'($urandom_range(0, 1));
    repeat (S + 1) tick();
    start_static(6);
    repeat (7) tick();
    chk1("b2b_done_cycle", done, 1'b1);
    start_static(5);
    wait_drain(20);

    // Randomised per-cycle phases
    repeat (25) begin
      len = int'($urandom_range(1, 24));
      fill_random(len);
      run_seq(-1, -1);
      wait_drain(len + 10);
    end

    // Reset in the middle of a window
    phase_in  = $urandom();
    phase_ref = 1'b0;
    repeat (S + 1) tick();
    start_static(50);
    repeat (10) tick();
    axi_rstn = 1'b0;
    sbq.delete();
    model_spins = '0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_spins", spins, '0);
    tick();
    axi_rstn = 1'b1;
    repeat (S + 2) tick();
    start_static(5);
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
